// File: rtl/scarv_cop_dispatch_q.sv
// Instruction dispatch queue between ISE coprocessor decode and execute.
// In-order FIFO that applies the MCCR feature-enable check when an entry is enqueued.
module scarv_cop_dispatch_q #(
    parameter int unsigned DEPTH         = 4,
    parameter logic [7:0]  MCCR_RESET    = 8'hFF,
    parameter bit          FEATURE_CHECK = 1'b1
) (
    input  logic                         g_clk,
    input  logic                         g_reset,
    input  logic                         mccr_wen,
    input  logic [7:0]                   mccr_wdata,
    output logic [7:0]                   mccr,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_encoded,
    input  logic [3:0]                   in_class,
    input  logic [4:0]                   in_subclass,
    input  logic [2:0]                   in_pw,
    input  logic                         in_exception,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_encoded,
    output logic [3:0]                   out_class,
    output logic [4:0]                   out_subclass,
    output logic [2:0]                   out_pw,
    output logic [1:0]                   out_cause,
    output logic                         out_exception,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Instruction class codes
    localparam logic [3:0] ICLASS_PACKED_ARITH = 4'd1;
    localparam logic [3:0] ICLASS_LOADSTORE    = 4'd3;
    localparam logic [3:0] ICLASS_RANDOM       = 4'd4;
    localparam logic [3:0] ICLASS_MP           = 4'd6;

    // Load/store subclasses that use scatter/gather
    localparam logic [4:0] LS_SCATTER_B = 5'd8;
    localparam logic [4:0] LS_GATHER_B  = 5'd9;
    localparam logic [4:0] LS_SCATTER_H = 5'd10;
    localparam logic [4:0] LS_GATHER_H  = 5'd11;

    // Pack width codes
    localparam logic [2:0] PW_1  = 3'd1;
    localparam logic [2:0] PW_2  = 3'd2;
    localparam logic [2:0] PW_4  = 3'd3;
    localparam logic [2:0] PW_8  = 3'd4;
    localparam logic [2:0] PW_16 = 3'd5;

    localparam int unsigned MCCR_R   = 0;
    localparam int unsigned MCCR_MP  = 1;
    localparam int unsigned MCCR_SG  = 2;
    localparam int unsigned MCCR_P32 = 3;
    localparam int unsigned MCCR_P16 = 4;
    localparam int unsigned MCCR_P8  = 5;
    localparam int unsigned MCCR_P4  = 6;
    localparam int unsigned MCCR_P2  = 7;

    logic [31:0] mem_enc   [DEPTH];
    logic [3:0]  mem_class [DEPTH];
    logic [4:0]  mem_sub   [DEPTH];
    logic [2:0]  mem_pw    [DEPTH];
    logic [1:0]  mem_cause [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    mccr_q;

    logic       push, pop;
    logic       feature_miss;
    logic [1:0] cause_in;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mccr      = mccr_q;
    assign in_ready  = !full && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        feature_miss = 1'b0;
        case (in_class)
            ICLASS_RANDOM: feature_miss = !mccr_q[MCCR_R];
            ICLASS_MP:     feature_miss = !mccr_q[MCCR_MP];
            ICLASS_LOADSTORE: begin
                if (in_subclass == LS_SCATTER_B || in_subclass == LS_GATHER_B ||
                    in_subclass == LS_SCATTER_H || in_subclass == LS_GATHER_H) begin
                    feature_miss = !mccr_q[MCCR_SG];
                end
            end
            ICLASS_PACKED_ARITH: begin
                case (in_pw)
                    PW_1:    feature_miss = !mccr_q[MCCR_P32];
                    PW_2:    feature_miss = !mccr_q[MCCR_P2];
                    PW_4:    feature_miss = !mccr_q[MCCR_P4];
                    PW_8:    feature_miss = !mccr_q[MCCR_P8];
                    PW_16:   feature_miss = !mccr_q[MCCR_P16];
                    default: feature_miss = 1'b0;
                endcase
            end
            default: feature_miss = 1'b0;
        endcase
    end

    // Decode-detected illegal encodings take priority over feature misses
    always_comb begin
        cause_in = 2'd0;
        if (in_exception) begin
            cause_in = 2'd1;
        end else if (FEATURE_CHECK && feature_miss) begin
            cause_in = 2'd2;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            mccr_q <= MCCR_RESET;
        end else if (mccr_wen) begin
            mccr_q <= mccr_wdata;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_enc[i]   <= '0;
                mem_class[i] <= '0;
                mem_sub[i]   <= '0;
                mem_pw[i]    <= '0;
                mem_cause[i] <= '0;
            end
        end else if (push) begin
            mem_enc[wr_ptr_q]   <= in_encoded;
            mem_class[wr_ptr_q] <= in_class;
            mem_sub[wr_ptr_q]   <= in_subclass;
            mem_pw[wr_ptr_q]    <= in_pw;
            mem_cause[wr_ptr_q] <= cause_in;
        end
    end

    assign out_encoded   = mem_enc[rd_ptr_q];
    assign out_class     = mem_class[rd_ptr_q];
    assign out_subclass  = mem_sub[rd_ptr_q];
    assign out_pw        = mem_pw[rd_ptr_q];
    assign out_cause     = mem_cause[rd_ptr_q];
    assign out_exception = (mem_cause[rd_ptr_q] != 2'd0);

endmodule

// File: tb/tb_scarv_cop_dispatch_q.sv
// Directed bench for scarv_cop_dispatch_q; a scoreboard queue holds expected
// entries in order and an independent model computes the stored cause.
module tb_scarv_cop_dispatch_q;

    localparam int unsigned DEPTH = 4;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        mccr_wen;
    logic [7:0]  mccr_wdata;
    logic [7:0]  mccr;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_encoded;
    logic [3:0]  in_class;
    logic [4:0]  in_subclass;
    logic [2:0]  in_pw;
    logic        in_exception;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_encoded;
    logic [3:0]  out_class;
    logic [4:0]  out_subclass;
    logic [2:0]  out_pw;
    logic [1:0]  out_cause;
    logic        out_exception;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    typedef struct packed {
        logic [31:0] enc;
        logic [3:0]  cls;
        logic [4:0]  sub;
        logic [2:0]  pw;
        logic [1:0]  cause;
    } ent_t;

    ent_t       sb[$];
    ent_t       head;
    logic [7:0] mccr_m;
    int         n_checks = 0;
    int         n_fail   = 0;

    scarv_cop_dispatch_q #(.DEPTH(DEPTH), .MCCR_RESET(8'hFF), .FEATURE_CHECK(1'b1)) dut (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .mccr_wen     (mccr_wen),
        .mccr_wdata   (mccr_wdata),
        .mccr         (mccr),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_encoded   (in_encoded),
        .in_class     (in_class),
        .in_subclass  (in_subclass),
        .in_pw        (in_pw),
        .in_exception (in_exception),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_encoded  (out_encoded),
        .out_class    (out_class),
        .out_subclass (out_subclass),
        .out_pw       (out_pw),
        .out_cause    (out_cause),
        .out_exception(out_exception),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference cause: class 1 packed, 3 load/store, 4 random, 6 multi-precision
    function automatic logic [1:0] model_cause(input logic [3:0] cls, input logic [4:0] sub,
                                               input logic [2:0] pw, input logic exc,
                                               input logic [7:0] m);
        logic miss;
        miss = 1'b0;
        if (cls == 4'd4 && !m[0]) miss = 1'b1;
        if (cls == 4'd6 && !m[1]) miss = 1'b1;
        if (cls == 4'd3 && sub >= 5'd8 && sub <= 5'd11 && !m[2]) miss = 1'b1;
        if (cls == 4'd1) begin
            if (pw == 3'd1 && !m[3]) miss = 1'b1;
            if (pw == 3'd5 && !m[4]) miss = 1'b1;
            if (pw == 3'd4 && !m[5]) miss = 1'b1;
            if (pw == 3'd3 && !m[6]) miss = 1'b1;
            if (pw == 3'd2 && !m[7]) miss = 1'b1;
        end
        if (exc) return 2'd1;
        if (miss) return 2'd2;
        return 2'd0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] enc, input logic [3:0] cls,
                         input logic [4:0] sub, input logic [2:0] pw, input logic exc);
        in_valid     = v;
        in_encoded   = enc;
        in_class     = cls;
        in_subclass  = sub;
        in_pw        = pw;
        in_exception = exc;
    endtask

    // One clock: check handshakes at negedge, update scoreboard, advance past posedge.
    task automatic cycle();
        logic exp_ready, do_push, do_pop;
        ent_t e;
        @(negedge g_clk);
        exp_ready = (sb.size() < DEPTH) && !flush;
        do_push   = in_valid && exp_ready;
        do_pop    = (sb.size() != 0) && out_ready && !flush;
        chk("count", 64'(count), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (do_pop) begin
            head = sb.pop_front();
            chk("head_fields", {out_encoded, out_class, out_subclass, out_pw, out_cause},
                64'(head));
            chk("out_exception", 64'(out_exception), 64'(head.cause != 2'd0));
        end
        if (do_push) begin
            e.enc   = in_encoded;
            e.cls   = in_class;
            e.sub   = in_subclass;
            e.pw    = in_pw;
            e.cause = model_cause(in_class, in_subclass, in_pw, in_exception, mccr_m);
            sb.push_back(e);
        end
        if (flush) sb.delete();
        @(posedge g_clk);
        if (mccr_wen) mccr_m = mccr_wdata;
        #1;
    endtask

    initial begin
        g_reset    = 1'b1;
        mccr_wen   = 1'b0;
        mccr_wdata = 8'h00;
        flush      = 1'b0;
        out_ready  = 1'b0;
        mccr_m     = 8'hFF;
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", {out_encoded, out_class, out_subclass, out_pw, out_cause,
                             out_exception}, 64'd0);
        chk("rst_mccr", 64'(mccr), 64'hFF);
        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;

        // Fill to DEPTH with execute stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 4'd5, 5'(i), 3'd0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_encoded), 64'hA000_0000);

        // Push refused while full, pop accepted; then streaming across pointer wrap
        out_ready = 1'b1;
        drive(1'b1, 32'hBAD0_0000, 4'd5, 5'd0, 3'd0, 1'b0);
        cycle();
        chk("full_pushpop_count", 64'(count), 64'd3);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'hB000_0000 + 32'(i), 4'd2, 5'(i), 3'(i), 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        repeat (4) cycle();
        chk("drained_empty", 64'(empty), 64'd1);

        // MCCR write: same-cycle push uses old value, later pushes the new one
        out_ready  = 1'b0;
        mccr_wen   = 1'b1;
        mccr_wdata = 8'hFE;
        drive(1'b1, 32'hC000_0000, 4'd4, 5'd0, 3'd0, 1'b0);
        cycle();
        mccr_wen = 1'b0;
        chk("mccr_fe", 64'(mccr), 64'hFE);
        drive(1'b1, 32'hC000_0001, 4'd4, 5'd0, 3'd0, 1'b0);
        cycle();
        drive(1'b1, 32'hC000_0002, 4'd4, 5'd0, 3'd0, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // P8 and SG cleared: packed PW_8 faults, PW_16 does not; gather faults
        mccr_wen   = 1'b1;
        mccr_wdata = 8'hDB;
        cycle();
        mccr_wen = 1'b0;
        drive(1'b1, 32'hD000_0000, 4'd1, 5'd0, 3'd4, 1'b0);
        cycle();
        drive(1'b1, 32'hD000_0001, 4'd1, 5'd0, 3'd5, 1'b0);
        cycle();
        drive(1'b1, 32'hD000_0002, 4'd3, 5'd11, 3'd0, 1'b0);
        cycle();
        drive(1'b1, 32'hD000_0003, 4'd6, 5'd0, 3'd0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        repeat (2) cycle();

        // Flush with three queued, push and pop offered; MCCR write still lands
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hE000_0000 + 32'(i), 4'd5, 5'd0, 3'd0, 1'b0);
            cycle();
        end
        chk("preflush_count", 64'(count), 64'd3);
        flush      = 1'b1;
        out_ready  = 1'b1;
        mccr_wen   = 1'b1;
        mccr_wdata = 8'h00;
        drive(1'b1, 32'hEEEE_EEEE, 4'd5, 5'd0, 3'd0, 1'b0);
        cycle();
        flush    = 1'b0;
        mccr_wen = 1'b0;
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_mccr", 64'(mccr), 64'h00);

        // Refill after flush, then asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hF000_0000 + 32'(i), 4'd4, 5'd0, 3'd0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 4'd0, 5'd0, 3'd0, 1'b0);
        out_ready = 1'b1;
        cycle();
        chk("prereset_count", 64'(count), 64'd1);
        #2 g_reset = 1'b1;
        #1;
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_mccr", 64'(mccr), 64'hFF);
        sb.delete();
        mccr_m = 8'hFF;
        @(posedge g_clk);
        #1 g_reset = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
